// File: rtl/imem_loader_if.sv
// Byte-stream receive handshake and instruction-memory write port used by imem_loader.
// The master side is the loader; the slave side is the byte source plus the imu.
interface imem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_wen, mem_addr, mem_data
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_wen, mem_addr, mem_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a count/data/checksum byte frame, writes one
// 32-bit word per 4 bytes into the imu and holds the CPU in clear while loading.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_clr,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    words_loaded
);
    localparam int MAX_WORDS = (2 ** ADDR_W) / 4;

    typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, ERR} state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        count_n;
    logic [7:0]        word_cnt;
    logic [7:0]        sum;
    logic [1:0]        byte_cnt;
    logic [DATA_W-1:0] word;
    logic              rx_ready;
    logic              mem_wen;
    logic              xfer;
    logic              count_bad;

    assign xfer      = bus.rx_valid & rx_ready;
    assign count_bad = (bus.rx_data == 8'd0) || (int'(bus.rx_data) > MAX_WORDS);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        mem_wen    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = COUNT;
            end
            COUNT: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) state_next = count_bad ? ERR : DATA;
            end
            DATA: begin
                rx_ready = 1'b1;
                if (bus.rx_valid && byte_cnt == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                mem_wen    = 1'b1;
                state_next = (word_cnt + 8'd1 == count_n) ? CHECK : DATA;
            end
            CHECK: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) state_next = IDLE;
            end
            ERR: begin
                if (start) state_next = COUNT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_n  <= 8'd0;
            word_cnt <= 8'd0;
            sum      <= 8'd0;
            byte_cnt <= 2'd0;
            word     <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE, ERR: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        word_cnt <= 8'd0;
                        sum      <= 8'd0;
                        byte_cnt <= 2'd0;
                    end
                end
                COUNT: begin
                    if (xfer) begin
                        count_n <= bus.rx_data;
                        sum     <= bus.rx_data;
                        if (count_bad) err <= 1'b1;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        word     <= {word[DATA_W-9:0], bus.rx_data};
                        sum      <= sum + bus.rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 8'd1;
                end
                CHECK: begin
                    if (xfer) begin
                        if (bus.rx_data == sum) done <= 1'b1;
                        else                    err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address wraps modulo 2**ADDR_W; word_cnt still holds the pre-increment index in WRITE.
    assign bus.mem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'({word_cnt, 2'b00});
    assign bus.mem_data  = word;
    assign bus.mem_wen   = mem_wen;
    assign bus.rx_ready  = rx_ready;
    assign busy          = (state == COUNT) || (state == DATA) || (state == WRITE) || (state == CHECK);
    assign cpu_clr       = (state != IDLE) || err;
    assign words_loaded  = word_cnt;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of frames plus hand-written sequences for
// the 64-word load, mid-load reset and start-while-busy cases.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic       cpu_clr;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] words_loaded;

    imem_loader_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    imem_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .start        (start),
        .bus          (bus),
        .cpu_clr      (cpu_clr),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       count;
        logic [2:0][31:0] words;
        logic [7:0]       csum;
        logic             toggle;
        logic             exp_done;
        logic             exp_err;
        logic [7:0]       exp_wl;
    } frame_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Write monitor, sampled mid-cycle.
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          proto_bad = 0;
    bit          prev_xfer = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_wen) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_data);
            if (!prev_xfer)   proto_bad++;
            if (bus.rx_ready) proto_bad++;
            if (err)          proto_bad++;
        end
        prev_xfer = bus.rx_valid && bus.rx_ready;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Presents one byte and returns just after the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] b, input logic toggle);
        int n = 0;
        if (toggle) begin
            bus.rx_valid = 1'b0;
            step();
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_mem_wen"},  32'(bus.mem_wen),  32'd0);
        check({tag, "_busy"},     32'(busy),         32'd0);
        check({tag, "_done"},     32'(done),         32'd0);
        check({tag, "_err"},      32'(err),          32'd0);
        check({tag, "_cpu_clr"},  32'(cpu_clr),      32'd0);
        check({tag, "_addr"},     32'(bus.mem_addr), 32'h00);
        check({tag, "_data"},     bus.mem_data,      32'h0);
        check({tag, "_wl"},       32'(words_loaded), 32'd0);
    endtask

    task automatic run_frame(input string tag, input frame_t f);
        int base = wr_addr.size();
        pulse_start();
        check({tag, "_clr_rise"}, 32'(cpu_clr), 32'd1);
        check({tag, "_busy"},     32'(busy),    32'd1);
        send_byte(f.count, f.toggle);
        for (int w = 0; w < int'(f.exp_wl); w++)
            for (int b = 3; b >= 0; b--)
                send_byte(f.words[w][8*b +: 8], f.toggle);
        if (f.exp_wl != 8'd0) send_byte(f.csum, f.toggle);
        step();
        step();
        check({tag, "_done"},     32'(done),         32'(f.exp_done));
        check({tag, "_err"},      32'(err),          32'(f.exp_err));
        check({tag, "_wl"},       32'(words_loaded), 32'(f.exp_wl));
        check({tag, "_idle"},     32'(busy),         32'd0);
        check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check({tag, "_cpu_clr"},  32'(cpu_clr),      32'(f.exp_err));
        check({tag, "_nwrites"},  32'(wr_addr.size() - base), 32'(f.exp_wl));
        for (int w = 0; w < int'(f.exp_wl) && base + w < wr_addr.size(); w++) begin
            check($sformatf("%s_addr%0d", tag, w), 32'(wr_addr[base+w]), 32'(4 * w));
            check($sformatf("%s_data%0d", tag, w), wr_data[base+w], f.words[w]);
        end
    endtask

    frame_t tbl[6];

    initial begin
        logic [7:0]  csum;
        logic [31:0] wd;
        int          base;
        int          bad_cnt;

        tbl[0] = '{count: 8'h01, words: {32'h0, 32'h0, 32'h20080005}, csum: 8'h2E,
                   toggle: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_wl: 8'd1};
        tbl[1] = '{count: 8'h01, words: {32'h0, 32'h0, 32'h20080005}, csum: 8'h2F,
                   toggle: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_wl: 8'd1};
        tbl[2] = '{count: 8'h00, words: '0, csum: 8'h00,
                   toggle: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_wl: 8'd0};
        tbl[3] = '{count: 8'h41, words: '0, csum: 8'h00,
                   toggle: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_wl: 8'd0};
        tbl[4] = '{count: 8'h03, words: {32'hDEADBEEF, 32'hA5A5A5A5, 32'h11223344}, csum: 8'h79,
                   toggle: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_wl: 8'd3};
        tbl[5] = '{count: 8'h02, words: {32'h0, 32'h00000100, 32'hFFFFFFFF}, csum: 8'hFF,
                   toggle: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_wl: 8'd2};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        clr_n = 1'b1;
        step();
        check("post_reset_clr", 32'(cpu_clr), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("f%0d", i), tbl[i]);
            // An erroring frame keeps the CPU in clear until the next start.
            if (tbl[i].exp_err) begin
                repeat (3) step();
                check($sformatf("f%0d_clr_hold", i), 32'(cpu_clr), 32'd1);
            end
        end

        // Full 64-word load: word k = {k,k,k,k}
        base = wr_addr.size();
        pulse_start();
        send_byte(8'h40, 1'b0);
        csum = 8'h40;
        for (int k = 0; k < 64; k++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(8'(k), 1'b0);
                csum = csum + 8'(k);
            end
        end
        send_byte(csum, 1'b0);
        step();
        check("max_done",    32'(done),         32'd1);
        check("max_err",     32'(err),          32'd0);
        check("max_wl",      32'(words_loaded), 32'd64);
        check("max_nwrites", 32'(wr_addr.size() - base), 32'd64);
        bad_cnt = 0;
        for (int k = 0; k < 64 && base + k < wr_addr.size(); k++) begin
            wd = {8'(k), 8'(k), 8'(k), 8'(k)};
            if (wr_addr[base+k] !== 8'(4 * k) || wr_data[base+k] !== wd) bad_cnt++;
        end
        check("max_content", 32'(bad_cnt), 32'd0);
        if (wr_addr.size() > 0)
            check("max_last_addr", 32'(wr_addr[wr_addr.size()-1]), 32'hFC);

        // Reset after the second of three words, then a clean reload
        base = wr_addr.size();
        pulse_start();
        send_byte(8'h03, 1'b0);
        for (int b = 3; b >= 0; b--) send_byte(8'(32'hCAFEF00D >> (8 * b)), 1'b0);
        for (int b = 3; b >= 0; b--) send_byte(8'(32'h12345678 >> (8 * b)), 1'b0);
        step();
        check("abort_nwrites", 32'(wr_addr.size() - base), 32'd2);
        check("abort_busy",    32'(busy),                  32'd1);
        clr_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        step();
        clr_n = 1'b1;
        step();
        run_frame("reload", tbl[0]);

        // start pulsed during DATA is ignored
        base = wr_addr.size();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h0B, 1'b0);
        send_byte(8'hAD, 1'b0);
        start = 1'b1;
        send_byte(8'hC0, 1'b0);
        start = 1'b0;
        check("busy_start_busy", 32'(busy), 32'd1);
        send_byte(8'hDE, 1'b0);
        send_byte(8'h57, 1'b0);
        step();
        check("busy_start_done",    32'(done), 32'd1);
        check("busy_start_err",     32'(err),  32'd0);
        check("busy_start_nwrites", 32'(wr_addr.size() - base), 32'd1);
        if (wr_addr.size() > base) begin
            check("busy_start_addr", 32'(wr_addr[base]), 32'h00);
            check("busy_start_data", wr_data[base],      32'h0BADC0DE);
        end

        check("write_protocol", 32'(proto_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
